// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Arbitrates halt (syscall), control redirects, the multi-cycle mult/div
// unit and register data hazards into PC / pipeline-register enables and
// synchronous bubble clears. All outputs are combinational from the current
// FSM state and this cycle's inputs.
//
// Build option: define HAZARD_FORWARD_EN when EX->ID and MEM->ID forwarding
// paths exist; only the load-use case then stalls. Without it, any pending
// write in EX or MEM to a register read in ID stalls.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,   // EX cycles a multiply occupies the unit (1..63)
    parameter int DIV_CYCLES  = 32   // EX cycles a divide occupies the unit (1..63)
) (
    input  logic       clk,
    input  logic       rst_n,
    // ID stage
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_md_op,
    input  logic       id_lhr_ren,
    // EX stage
    input  logic       ex_rf_wen,
    input  logic       ex_is_load,
    input  logic [4:0] ex_waddr,
    input  logic       ex_md_start,
    input  logic       ex_md_is_mult,
    // MEM stage
    input  logic       mem_rf_wen,
    input  logic [4:0] mem_waddr,
    input  logic       mem_redirect,
    // WB stage
    input  logic       wb_syscall,
    // pipeline control
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_clr,
    output logic       id_ex_clr,
    output logic       ex_mem_clr,
    // status
    output logic       md_busy,
    output logic       halted
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        HALT    = 2'd2
    } state_t;

    // md_cnt holds the number of MD_BUSY cycles remaining after the current one
    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [5:0] md_cnt_reg;
    logic [5:0] md_cnt_next;

    // ------------------------------------------------------------------
    // Register dependency detection, one lane per ID source operand.
    // Register 0 is hard-wired to zero, so a write to it never conflicts.
    // ------------------------------------------------------------------
    logic [1:0][4:0] src_reg;
    logic [1:0]      src_use;
    logic [1:0]      ex_match;
    logic [1:0]      mem_match;
    logic            load_use;
    logic            data_hazard;

    assign src_reg[0] = id_rs;
    assign src_reg[1] = id_rt;
    assign src_use[0] = id_use_rs;
    assign src_use[1] = id_use_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign ex_match[gi]  = src_use[gi] & ex_rf_wen & (ex_waddr != 5'd0)
                                   & (ex_waddr == src_reg[gi]);
            assign mem_match[gi] = src_use[gi] & mem_rf_wen & (mem_waddr != 5'd0)
                                   & (mem_waddr == src_reg[gi]);
        end
    endgenerate

    // A load in EX cannot forward its data until MEM completes
    assign load_use = ex_is_load & (|ex_match);

`ifdef HAZARD_FORWARD_EN
    // Forwarding covers every EX/MEM producer except a load still in EX
    assign data_hazard = load_use;
`else
    // No forwarding: wait until any in-flight producer has written back
    assign data_hazard = (|ex_match) | (|mem_match);
`endif

    // Mult/div results (and a new mult/div) must wait for the busy unit
    logic md_stall;
    assign md_stall = (state_reg == MD_BUSY) & (id_lhr_ren | id_md_op);

    // A redirect makes the EX instruction wrong-path, so its mult/div never issues
    logic md_issue;
    assign md_issue = ex_md_start & ~mem_redirect;

    // State and busy counter; reset abandons any operation or halt at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RUN;
            md_cnt_reg <= 6'd0;
        end else begin
            state_reg  <= state_next;
            md_cnt_reg <= md_cnt_next;
        end
    end

    // Next-state: syscall wins, a committed mult/div counts down even across redirects
    always_comb begin
        state_next  = state_reg;
        md_cnt_next = md_cnt_reg;
        unique case (state_reg)
            RUN: begin
                if (wb_syscall) begin
                    state_next  = HALT;
                    md_cnt_next = 6'd0;
                end else if (md_issue) begin
                    state_next  = MD_BUSY;
                    md_cnt_next = ex_md_is_mult ? MULT_LOAD : DIV_LOAD;
                end
            end
            MD_BUSY: begin
                if (wb_syscall) begin
                    state_next  = HALT;
                    md_cnt_next = 6'd0;
                end else if (md_cnt_reg == 6'd0) begin
                    state_next  = RUN;
                end else begin
                    md_cnt_next = md_cnt_reg - 6'd1;
                end
            end
            HALT: begin
                state_next  = HALT;
                md_cnt_next = 6'd0;
            end
            default: begin
                state_next  = RUN;
                md_cnt_next = 6'd0;
            end
        endcase
    end

    // Outputs: halt > redirect > mult/div stall > data stall > free-running
    always_comb begin
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        if_id_clr  = 1'b0;
        id_ex_clr  = 1'b0;
        ex_mem_clr = 1'b0;
        md_busy    = (state_reg == MD_BUSY);
        halted     = 1'b0;
        if (state_reg == HALT) begin
            // Freeze fetch and drain bubbles behind the syscall
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_clr  = 1'b1;
            ex_mem_clr = 1'b1;
            halted     = 1'b1;
        end else if (mem_redirect) begin
            // Squash the three younger wrong-path instructions, load the target PC
            if_id_clr  = 1'b1;
            id_ex_clr  = 1'b1;
            ex_mem_clr = 1'b1;
        end else if (md_stall || data_hazard) begin
            // Hold IF/ID, send a bubble down into EX
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_clr  = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. A stimulus process
// drives one input vector per cycle and pushes the reference model's
// expected outputs; a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

    localparam int MULT_CYC = 4;
    localparam int DIV_CYC  = 32;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_waddr, mem_waddr;
    logic       id_use_rs, id_use_rt, id_md_op, id_lhr_ren;
    logic       ex_rf_wen, ex_is_load, ex_md_start, ex_md_is_mult;
    logic       mem_rf_wen, mem_redirect, wb_syscall;
    logic       pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr, md_busy, halted;

    hazard_ctrl #(
        .MULT_CYCLES(MULT_CYC),
        .DIV_CYCLES (DIV_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_md_op     (id_md_op),
        .id_lhr_ren   (id_lhr_ren),
        .ex_rf_wen    (ex_rf_wen),
        .ex_is_load   (ex_is_load),
        .ex_waddr     (ex_waddr),
        .ex_md_start  (ex_md_start),
        .ex_md_is_mult(ex_md_is_mult),
        .mem_rf_wen   (mem_rf_wen),
        .mem_waddr    (mem_waddr),
        .mem_redirect (mem_redirect),
        .wb_syscall   (wb_syscall),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_clr    (if_id_clr),
        .id_ex_clr    (id_ex_clr),
        .ex_mem_clr   (ex_mem_clr),
        .md_busy      (md_busy),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, ex_waddr, mem_waddr;
        logic use_rs, use_rt, md_op, lhr, ex_wen, ex_load;
        logic md_start, md_mult, mem_wen, redirect, syscall;
    } stim_t;

    // {pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr, md_busy, halted}
    typedef struct {
        int         id;
        logic [6:0] exp;
        string      tag;
    } txn_t;

    txn_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;

    // Reference model state: halted flag and number of busy cycles still owed
    bit   m_halted   = 1'b0;
    int   m_busy_left = 0;

    function automatic stim_t idle();
        stim_t s;
        s.rs = 0; s.rt = 0; s.ex_waddr = 0; s.mem_waddr = 0;
        s.use_rs = 0; s.use_rt = 0; s.md_op = 0; s.lhr = 0; s.ex_wen = 0;
        s.ex_load = 0; s.md_start = 0; s.md_mult = 0; s.mem_wen = 0;
        s.redirect = 0; s.syscall = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim(int syscall_odds);
        stim_t s;
        s.rs        = 5'($urandom_range(0, 7));
        s.rt        = 5'($urandom_range(0, 7));
        s.ex_waddr  = 5'($urandom_range(0, 7));
        s.mem_waddr = 5'($urandom_range(0, 7));
        s.use_rs    = ($urandom_range(0, 1) == 1);
        s.use_rt    = ($urandom_range(0, 1) == 1);
        s.md_op     = ($urandom_range(0, 4) == 0);
        s.lhr       = ($urandom_range(0, 4) == 0);
        s.ex_wen    = ($urandom_range(0, 9) < 6);
        s.ex_load   = ($urandom_range(0, 9) < 3);
        s.md_start  = ($urandom_range(0, 19) == 0);
        s.md_mult   = ($urandom_range(0, 1) == 1);
        s.mem_wen   = ($urandom_range(0, 1) == 1);
        s.redirect  = ($urandom_range(0, 9) == 0);
        s.syscall   = (syscall_odds > 0) && ($urandom_range(1, syscall_odds) == 1);
        return s;
    endfunction

    // Does this source operand read a register that a pending writer targets?
    function automatic bit depends(logic use_f, logic [4:0] r, logic wen, logic [4:0] waddr);
        return use_f && wen && (waddr != 0) && (waddr == r);
    endfunction

    // Expected outputs for one cycle from the model state and the inputs
    function automatic logic [6:0] expect_out(stim_t s);
        bit busy = (m_busy_left > 0);
        bit ld_use, raw, hazard;
        ld_use = s.ex_load && (depends(s.use_rs, s.rs, s.ex_wen, s.ex_waddr) ||
                               depends(s.use_rt, s.rt, s.ex_wen, s.ex_waddr));
        raw    = depends(s.use_rs, s.rs, s.ex_wen, s.ex_waddr)   ||
                 depends(s.use_rt, s.rt, s.ex_wen, s.ex_waddr)   ||
                 depends(s.use_rs, s.rs, s.mem_wen, s.mem_waddr) ||
                 depends(s.use_rt, s.rt, s.mem_wen, s.mem_waddr);
`ifdef HAZARD_FORWARD_EN
        hazard = ld_use;
`else
        hazard = raw;
`endif
        if (m_halted)                      return 7'b0001101;
        if (s.redirect)                    return {5'b11111, busy, 1'b0};
        if (busy && (s.lhr || s.md_op))    return {5'b00010, busy, 1'b0};
        if (hazard)                        return {5'b00010, busy, 1'b0};
        return {5'b11000, busy, 1'b0};
    endfunction

    // Advance the model across the clock edge that ends this cycle
    task automatic model_advance(stim_t s);
        if (m_halted) return;
        if (s.syscall) begin
            m_halted    = 1'b1;
            m_busy_left = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left = m_busy_left - 1;
        end else if (s.md_start && !s.redirect) begin
            m_busy_left = s.md_mult ? MULT_CYC : DIV_CYC;
        end
    endtask

    task automatic drive(stim_t s);
        id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
        id_md_op = s.md_op; id_lhr_ren = s.lhr;
        ex_rf_wen = s.ex_wen; ex_is_load = s.ex_load; ex_waddr = s.ex_waddr;
        ex_md_start = s.md_start; ex_md_is_mult = s.md_mult;
        mem_rf_wen = s.mem_wen; mem_waddr = s.mem_waddr;
        mem_redirect = s.redirect; wb_syscall = s.syscall;
    endtask

    task automatic step(stim_t s, string tag);
        txn_t t;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(s);
        t.id  = txn_id++;
        t.exp = expect_out(s);
        t.tag = tag;
        q.push_back(t);
        model_advance(s);
    endtask

    // Assert reset between edges; outputs must drop to reset values immediately
    task automatic do_reset(string tag);
        txn_t t;
        @(posedge clk);
        #1;
        drive(idle());
        rst_n       = 1'b0;
        m_halted    = 1'b0;
        m_busy_left = 0;
        t.id  = txn_id++;
        t.exp = 7'b1100000;
        t.tag = tag;
        q.push_back(t);
    endtask

    // Monitor: one comparison per presented cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            txn_t t;
            logic [6:0] got;
            t   = q.pop_front();
            got = {pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr, md_busy, halted};
            checks++;
            if (got !== t.exp) begin
                errors++;
                $display("FAIL %s txn %0d: got %b required %b (pc_en,if_id_en,if_id_clr,id_ex_clr,ex_mem_clr,md_busy,halted)",
                         t.tag, t.id, got, t.exp);
            end else begin
                $display("txn %0d %s outputs %b", t.id, t.tag, got);
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        drive(idle());

        do_reset("reset");
        step(idle(), "idle_run");

        // Load-use on rs, then same with destination r0
        s = idle(); s.ex_load = 1; s.ex_wen = 1; s.ex_waddr = 8; s.rs = 8; s.use_rs = 1;
        step(s, "load_use");
        s.ex_waddr = 0; s.rs = 0;
        step(s, "load_use_r0");

        // MEM-stage producer on rt: stall only without forwarding
        s = idle(); s.mem_wen = 1; s.mem_waddr = 5; s.rt = 5; s.use_rt = 1;
        step(s, "mem_raw");

        // Divide: busy window with HI/LO reader stalling until it ends
        s = idle(); s.md_start = 1; s.md_mult = 0;
        step(s, "div_start");
        s = idle(); s.lhr = 1;
        for (int i = 0; i < DIV_CYC + 2; i++) step(s, "div_lhr");

        // Redirect with load-use and mult/div start: flush, no busy entry
        s = idle(); s.redirect = 1; s.md_start = 1; s.md_mult = 1;
        s.ex_load = 1; s.ex_wen = 1; s.ex_waddr = 8; s.rs = 8; s.use_rs = 1;
        step(s, "redirect_prec");
        s = idle(); s.md_op = 1;
        step(s, "after_redirect");

        // Redirect during busy keeps counting; syscall mid-busy halts
        s = idle(); s.md_start = 1; s.md_mult = 1;
        step(s, "mult_start");
        s = idle(); s.redirect = 1;
        step(s, "busy_redirect");
        s = idle(); s.syscall = 1;
        step(s, "busy_syscall");
        for (int i = 0; i < 4; i++) step(rand_stim(0), "halt_hold");
        do_reset("reset_from_halt");
        step(idle(), "post_reset");

        // Reset in the middle of a divide
        s = idle(); s.md_start = 1;
        step(s, "div_start2");
        for (int i = 0; i < 5; i++) step(idle(), "div_busy");
        do_reset("reset_mid_busy");
        s = idle(); s.md_op = 1;
        step(s, "post_reset_mdop");

        // Randomized traffic with periodic resets
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 249) do_reset("rand_reset");
            else step(rand_stim(300), "rand");
        end

        @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4, meaning EX cycles a multiply occupies the mult/div unit (range 1..63).
REQ-002 SHALL have parameter DIV_CYCLES, default 32, meaning EX cycles a divide occupies the mult/div unit (range 1..63).
REQ-003 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs, id_rt  in  5 each  ID-stage source register numbers.
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
- id_md_op  in  1  ID instruction is mult/div.
- id_lhr_ren  in  1  ID instruction reads HI/LO.
- ex_rf_wen, ex_is_load  in  1 each  ID/EX-registered write-enable and load flag.
- ex_waddr  in  5  EX destination register.
- ex_md_start, ex_md_is_mult  in  1 each  EX issues mult/div this cycle; 1 = multiply.
- mem_rf_wen  in  1  and  mem_waddr  in  5  MEM destination.
- mem_redirect  in  1  branch taken or jump resolved in MEM.
- wb_syscall  in  1  syscall in WB.
- pc_en, if_id_en  out  1 each  PC / IF-ID load enables.
- if_id_clr, id_ex_clr, ex_mem_clr  out  1 each  synchronous bubble inserts (id_ex_clr drives the ID/EX register clr).
- md_busy, halted  out  1 each  status.

Function
REQ-004 SHALL implement FSM states RUN, MD_BUSY, HALT plus a 6-bit down-counter md_cnt.
REQ-005 SHALL compute all outputs combinationally from current state and inputs, with zero-cycle latency.
REQ-006 SHALL apply priority HALT > redirect > mult/div stall > data stall; only the highest active condition drives outputs.
REQ-007 SHALL, in HALT, drive pc_en=0, if_id_en=0, id_ex_clr=1, ex_mem_clr=1, halted=1, and remain in HALT until reset.
REQ-008 SHALL enter HALT on the clock edge after wb_syscall=1 from RUN or MD_BUSY, discarding md_cnt.
REQ-009 SHALL, when mem_redirect=1 and not HALT, drive if_id_clr=1, id_ex_clr=1, ex_mem_clr=1 for exactly that cycle, with pc_en=1 and if_id_en=1.
REQ-010 SHALL ignore ex_md_start when mem_redirect=1 in the same cycle, because the EX instruction is wrong-path.
REQ-011 SHALL, in RUN with ex_md_start=1, load md_cnt with MULT_CYCLES-1 if ex_md_is_mult else DIV_CYCLES-1 and enter MD_BUSY next edge.
REQ-012 SHALL decrement md_cnt each cycle in MD_BUSY, return to RUN on the edge where md_cnt==0, and hold md_busy=1 in every MD_BUSY cycle.
REQ-013 SHALL, in MD_BUSY with (id_lhr_ren or id_md_op)=1, stall: pc_en=0, if_id_en=0, id_ex_clr=1.
REQ-014 SHALL let a redirect during MD_BUSY flush the pipeline while md_cnt keeps counting, because the issued operation is committed.
REQ-015 SHALL define load-use as ex_is_load & ex_rf_wen & ex_waddr!=0 & ((id_use_rs & ex_waddr==id_rs) | (id_use_rt & ex_waddr==id_rt)).
REQ-016 SHALL respond to a data hazard with pc_en=0, if_id_en=0, id_ex_clr=1, ex_mem_clr=0, if_id_clr=0.
REQ-017 SHALL otherwise drive pc_en=1, if_id_en=1 and all clears 0.

Reset
REQ-018 SHALL, on rst_n=0, asynchronously force state=RUN and md_cnt=0, giving outputs pc_en=1, if_id_en=1, all clears 0, md_busy=0, halted=0.
REQ-019 SHALL, on reset mid-MD_BUSY or in HALT, abandon the state immediately; the first edge after release evaluates from RUN.

Configuration
REQ-020 SHALL, with HAZARD_FORWARD_EN defined, treat only the load-use case of REQ-015 as a data hazard, since forwarding paths exist.
REQ-021 SHALL, without HAZARD_FORWARD_EN, also treat any non-zero match of id_rs/id_rt (with use flag) against ex_waddr (ex_rf_wen=1) or mem_waddr (mem_rf_wen=1) as a data hazard.

Verification
REQ-022 SHALL cover load-use: ex_is_load=1, ex_rf_wen=1, ex_waddr=8, id_rs=8, id_use_rs=1 -> pc_en=0, if_id_en=0, id_ex_clr=1 for one cycle; with ex_waddr=0 -> no stall.
REQ-023 SHALL cover divide: ex_md_start=1, ex_md_is_mult=0 with DIV_CYCLES=32 -> md_busy=1 for 32 cycles; id_lhr_ren=1 in that window stalls until md_busy falls.
REQ-024 SHALL cover redirect precedence: mem_redirect=1 together with load-use and ex_md_start=1 -> all three clears=1, pc_en=1, no MD_BUSY entry.
REQ-025 SHALL cover syscall: wb_syscall=1 during MD_BUSY -> HALT next edge, halted=1, pc_en=0, persisting until rst_n pulse, then outputs at reset values.
REQ-026 SHALL cover the macro: with HAZARD_FORWARD_EN undefined, mem_rf_wen=1, mem_waddr=5, id_rt=5, id_use_rt=1 -> stall; with it defined -> no stall.
